// File: rtl/alu_pipe_md.sv
// alu_pipe_md: RV32IM ALU behind valid/ready; fast ops in one cycle, iterative shift-add mul and restoring div (clk, rst, in_valid/in_ready, A, B, ALUControl -> out_valid/out_ready, Result, zero/neg/overflow/carry, busy)
module alu_pipe_md #(
  parameter int XLEN = 32,
  parameter int SHW = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] A,
  input  logic [XLEN-1:0] B,
  input  logic [4:0]      ALUControl,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] Result,
  output logic            zero,
  output logic            neg,
  output logic            overflow,
  output logic            carry,
  output logic            busy
);
  localparam int CW = $clog2(XLEN + 1);
  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;
  state_t state;
  logic [4:0] op;
  logic [XLEN-1:0] ma, mb, a_mag, b_mag, bx, fast_res, quo, rem, md_res;
  logic [2*XLEN-1:0] p, p_nx, prod;
  logic [XLEN:0] sum, madd, rsh, diff;
  logic [CW-1:0] cnt;
  logic is_sub, ovf, sa, sb, is_md, neg_q, neg_r, b_zero, last;
  assign in_ready = state == IDLE;
  assign out_valid = state == DONE;
  assign busy = state == MUL || state == DIV;
  assign is_sub = ALUControl inside {5'b00001, 5'b00101, 5'b00110};
  assign bx = is_sub ? ~B : B;
  assign sum = {1'b0, A} + {1'b0, bx} + {{XLEN{1'b0}}, is_sub};
  assign ovf = A[XLEN-1] == bx[XLEN-1] && sum[XLEN-1] != A[XLEN-1];
  always_comb begin
    fast_res = '0;
    case (ALUControl)
      5'b00000, 5'b00001: fast_res = sum[XLEN-1:0];
      5'b00010: fast_res = A & B;
      5'b00011: fast_res = A | B;
      5'b00100: fast_res = A ^ B;
      5'b00101: fast_res = {{(XLEN-1){1'b0}}, sum[XLEN-1] ^ ovf};
      5'b00110: fast_res = {{(XLEN-1){1'b0}}, ~sum[XLEN]};
      5'b01000: fast_res = A << B[SHW-1:0];
      5'b01001: fast_res = A >> B[SHW-1:0];
      5'b01010: fast_res = $signed(A) >>> B[SHW-1:0];
      default: fast_res = '0;
    endcase
  end
  assign is_md = ALUControl[4:3] == 2'b10;
  assign sa = A[XLEN-1] && (ALUControl inside {5'b10001, 5'b10010, 5'b10100, 5'b10110});
  assign sb = B[XLEN-1] && (ALUControl inside {5'b10001, 5'b10100, 5'b10110});
  assign a_mag = sa ? -A : A;
  assign b_mag = sb ? -B : B;
  // p holds {accumulator, multiplier} while multiplying and {remainder, dividend/quotient} while dividing
  assign madd = {1'b0, p[2*XLEN-1:XLEN]} + {1'b0, p[0] ? ma : {XLEN{1'b0}}};
  assign rsh = {p[2*XLEN-1:XLEN], p[XLEN-1]};
  assign diff = rsh - {1'b0, mb};
  assign p_nx = state == MUL ? {madd, p[XLEN-1:1]} :
                diff[XLEN] ? {rsh[XLEN-1:0], p[XLEN-2:0], 1'b0} : {diff[XLEN-1:0], p[XLEN-2:0], 1'b1};
  assign prod = neg_q ? -p_nx : p_nx;
  assign quo = b_zero ? {XLEN{1'b1}} : neg_q ? -p_nx[XLEN-1:0] : p_nx[XLEN-1:0];
  assign rem = neg_r ? -p_nx[2*XLEN-1:XLEN] : p_nx[2*XLEN-1:XLEN];
  assign md_res = op[2] ? (op[1] ? rem : quo) : (op[1:0] == 2'b00 ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN]);
  assign last = cnt == CW'(1);
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      Result <= '0;
      {zero, neg, overflow, carry} <= '0;
      {neg_q, neg_r, b_zero} <= '0;
      op <= '0;
      ma <= '0;
      mb <= '0;
      p <= '0;
      cnt <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          op <= ALUControl;
          ma <= a_mag;
          mb <= b_mag;
          neg_q <= sa ^ sb;
          neg_r <= sa;
          b_zero <= ~|B;
          cnt <= CW'(XLEN);
          p <= {{XLEN{1'b0}}, ALUControl[2] ? a_mag : b_mag};
          if (is_md) state <= ALUControl[2] ? DIV : MUL;
          else begin
            Result <= fast_res;
            zero <= ~|fast_res;
            neg <= fast_res[XLEN-1];
            overflow <= ALUControl[4:1] == 4'b0000 && ovf;
            carry <= ALUControl[4:1] == 4'b0000 && sum[XLEN];
            state <= DONE;
          end
        end
        MUL, DIV: begin
          p <= p_nx;
          cnt <= cnt - 1'b1;
          if (last) begin
            Result <= md_res;
            zero <= ~|md_res;
            neg <= md_res[XLEN-1];
            overflow <= 1'b0;
            carry <= 1'b0;
            state <= DONE;
          end
        end
        DONE: if (out_ready) state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_pipe_md.sv
// tb_alu_pipe_md: scoreboard bench for alu_pipe_md against a plain-arithmetic reference model
module tb_alu_pipe_md;
  logic clk, rst, in_valid, in_ready, out_valid, out_ready, zero, neg, overflow, carry, busy;
  logic [31:0] A, B, Result;
  logic [4:0] ALUControl;
  int nchk = 0, nerr = 0, cyc = 0, mode = 0;
  typedef struct {
    logic [31:0] r;
    logic z, n, v, c;
    int lat;
    int acc;
  } exp_t;
  exp_t sbq[$];
  alu_pipe_md dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .A(A), .B(B),
    .ALUControl(ALUControl), .out_valid(out_valid), .out_ready(out_ready), .Result(Result),
    .zero(zero), .neg(neg), .overflow(overflow), .carry(carry), .busy(busy)
  );
  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end
  always @(posedge clk) cyc <= cyc + 1;
  initial begin
    out_ready = 1;
    forever begin
      @(posedge clk);
      #2;
      out_ready = mode == 0 ? 1'b1 : mode == 1 ? 1'($urandom_range(0, 1)) : 1'b0;
    end
  end
  task automatic check(string name, logic [63:0] got, logic [63:0] want);
    nchk++;
    if (got !== want) begin
      nerr++;
      $display("FAIL %s: got %h want %h at cycle %0d", name, got, want, cyc);
    end
  endtask
  function automatic exp_t model(logic [4:0] o, logic [31:0] a, logic [31:0] b);
    exp_t e;
    longint sa, sb, ua, ub, t;
    logic [63:0] pr;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'(a);
    ub = longint'(b);
    e = '{r: 0, z: 0, n: 0, v: 0, c: 0, lat: 1, acc: 0};
    case (o)
      5'd0: begin e.r = a + b; t = sa + sb; e.v = t != longint'($signed(e.r)); e.c = ((ua + ub) >> 32) != 0; end
      5'd1: begin e.r = a - b; t = sa - sb; e.v = t != longint'($signed(e.r)); e.c = a >= b; end
      5'd2: e.r = a & b;
      5'd3: e.r = a | b;
      5'd4: e.r = a ^ b;
      5'd5: e.r = {31'b0, sa < sb};
      5'd6: e.r = {31'b0, a < b};
      5'd8: e.r = a << b[4:0];
      5'd9: e.r = a >> b[4:0];
      5'd10: e.r = 32'($signed(a) >>> b[4:0]);
      5'd16: begin pr = 64'(ua * ub); e.r = pr[31:0]; end
      5'd17: begin pr = 64'(sa * sb); e.r = pr[63:32]; end
      5'd18: begin pr = 64'(sa * ub); e.r = pr[63:32]; end
      5'd19: begin pr = 64'(ua * ub); e.r = pr[63:32]; end
      5'd20: e.r = b == 0 ? 32'hFFFFFFFF : (a == 32'h80000000 && b == 32'hFFFFFFFF) ? a : 32'(sa / sb);
      5'd21: e.r = b == 0 ? 32'hFFFFFFFF : a / b;
      5'd22: e.r = b == 0 ? a : (a == 32'h80000000 && b == 32'hFFFFFFFF) ? 32'h0 : 32'(sa % sb);
      5'd23: e.r = b == 0 ? a : a % b;
      default: e.r = 0;
    endcase
    if (o >= 5'd16 && o <= 5'd23) e.lat = 33;
    e.z = e.r == 0;
    e.n = e.r[31];
    return e;
  endfunction
  task automatic issue(logic [4:0] o, logic [31:0] a, logic [31:0] b);
    exp_t e;
    int n = 0;
    @(negedge clk);
    while (!in_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      nchk++;
      nerr++;
      $display("FAIL issue_timeout: in_ready stayed 0 for %0d cycles", n);
      return;
    end
    in_valid = 1;
    ALUControl = o;
    A = a;
    B = b;
    @(posedge clk);
    #1;
    in_valid = 0;
    A = $urandom;
    B = $urandom;
    e = model(o, a, b);
    e.acc = cyc;
    sbq.push_back(e);
  endtask
  task automatic drain();
    int n = 0;
    while (sbq.size() > 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (sbq.size() > 0) begin
      nchk++;
      nerr++;
      $display("FAIL drain_timeout: %0d results outstanding", sbq.size());
      sbq.delete();
    end
  endtask
  initial begin
    exp_t h;
    int bc = 0;
    bit seen = 0, chk_rdy = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        bc = 0;
        seen = 0;
        chk_rdy = 0;
        continue;
      end
      if (chk_rdy) begin
        check("in_ready_after_handshake", in_ready, 1);
        chk_rdy = 0;
      end
      if (busy) bc++;
      if (out_valid) begin
        if (sbq.size() == 0) begin
          nchk++;
          nerr++;
          $display("FAIL spurious_out_valid: Result %h with no outstanding op", Result);
        end else begin
          h = sbq[0];
          if (!seen) begin
            check("latency", cyc - h.acc + 1, h.lat);
            check("busy_cycles", bc, h.lat - 1);
            seen = 1;
          end
          check("result", Result, h.r);
          check("flags_znvc", {zero, neg, overflow, carry}, {h.z, h.n, h.v, h.c});
          check("in_ready_in_done", in_ready, 0);
          if (out_ready) begin
            void'(sbq.pop_front());
            seen = 0;
            bc = 0;
            chk_rdy = 1;
          end
        end
      end
    end
  end
  initial begin
    logic [4:0] ops [19] = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd8, 5'd9, 5'd10,
                             5'd16, 5'd17, 5'd18, 5'd19, 5'd20, 5'd21, 5'd22, 5'd23, 5'd24};
    logic [31:0] sp [5] = '{32'h0, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF, 32'h1};
    int n;
    rst = 1;
    in_valid = 0;
    A = 0;
    B = 0;
    ALUControl = 0;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_result", Result, 0);
    check("rst_flags", {zero, neg, overflow, carry}, 0);
    check("rst_in_ready", in_ready, 1);
    issue(5'd0, 32'h7FFFFFFF, 32'h1);
    issue(5'd1, 32'd5, 32'd5);
    issue(5'd5, 32'h80000000, 32'h1);
    issue(5'd6, 32'h80000000, 32'h1);
    issue(5'd10, 32'h80000000, 32'd4);
    issue(5'd17, 32'hFFFFFFFF, 32'hFFFFFFFF);
    issue(5'd19, 32'hFFFFFFFF, 32'hFFFFFFFF);
    issue(5'd18, 32'hFFFFFFFF, 32'h2);
    issue(5'd20, 32'h80000000, 32'hFFFFFFFF);
    issue(5'd22, 32'h80000000, 32'hFFFFFFFF);
    issue(5'd21, 32'd7, 32'd0);
    issue(5'd23, 32'd7, 32'd0);
    issue(5'd20, -32'sd7, 32'd2);
    issue(5'd22, -32'sd7, 32'd2);
    issue(5'd20, 32'd7, 32'd0);
    issue(5'd24, 32'h1234, 32'h5678);
    drain();
    mode = 2;
    issue(5'd4, 32'hA5A5A5A5, 32'h0F0F0F0F);
    n = 0;
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("bp_out_valid_seen", out_valid, 1);
    in_valid = 1;
    ALUControl = 5'd1;
    A = 32'd100;
    B = 32'd1;
    repeat (10) @(negedge clk);
    in_valid = 0;
    mode = 0;
    drain();
    issue(5'd21, 32'hDEADBEEF, 32'd3);
    repeat (14) @(posedge clk);
    #1 rst = 1;
    @(posedge clk);
    #1 rst = 0;
    sbq.delete();
    @(negedge clk);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_busy", busy, 0);
    check("midrst_result", Result, 0);
    check("midrst_in_ready", in_ready, 1);
    issue(5'd0, 32'd40, 32'd2);
    drain();
    mode = 1;
    repeat (300) begin
      issue(ops[$urandom_range(0, 18)],
            $urandom_range(0, 2) == 0 ? sp[$urandom_range(0, 4)] : $urandom,
            $urandom_range(0, 2) == 0 ? sp[$urandom_range(0, 4)] : ($urandom_range(0, 1) ? $urandom_range(0, 40) : $urandom));
    end
    drain();
    mode = 0;
    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end
endmodule

// File: doc/alu_pipe_md.md
# alu_pipe_md

Sequential, parametrised successor to the single-cycle integer ALU. It executes the RV32I ALU operations with a registered result. It adds shifts, XOR, a signed-correct SLT and SLTU, and the full RV32M multiply/divide set through an iterative shift-add / restoring-divide datapath. It sits in the execute stage of the multi-cycle core behind a valid/ready handshake, so the control FSM can stall on long operations.

## Interface
- XLEN, default 32: operand/result width; power of two, ≥ 8.
- SHW, default $clog2(XLEN): shift-amount width, taken from B[SHW-1:0].

- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operation presented.
- in_ready  out  1  block can accept an operation.
- A, B  in  XLEN each  operands.
- ALUControl  in  5  operation code:
  - 00000 ADD, 00001 SUB, 00010 AND, 00011 OR, 00100 XOR, 00101 SLT, 00110 SLTU.
  - 01000 SLL, 01001 SRL, 01010 SRA.
  - 10000 MUL, 10001 MULH, 10010 MULHSU, 10011 MULHU.
  - 10100 DIV, 10101 DIVU, 10110 REM, 10111 REMU.
  - All other codes: Result = 0.
- out_valid  out  1  Result and flags valid.
- out_ready  in  1  consumer takes the result.
- Result  out  XLEN  registered result.
- zero, neg, overflow, carry  out  1 each  registered flags.
- busy  out  1  high while a multiply or divide is iterating.

## Operation
- States: IDLE, MUL, DIV, DONE.
- in_ready = (state == IDLE). An operation is accepted on a cycle where in_valid && in_ready.
- Accept from IDLE:
  - Fast ops (ADD..SRA, and undefined codes) compute combinationally from A, B, ALUControl, latch Result and flags, and go to DONE.
  - Mul ops latch operands and go to MUL; div ops latch operands and go to DIV. An iteration counter is loaded with XLEN.
- MUL: 2·XLEN-bit product.
  - Signedness per op: MUL/MULHU treat both operands as unsigned; MULH treats both as signed; MULHSU treats A as signed and B as unsigned.
  - Signed operands are converted to magnitudes, multiplied, and the product is negated when the signs differ.
  - One shift-add per cycle.
  - MUL returns product[XLEN-1:0]; the others return product[2·XLEN-1:XLEN].
- DIV: restoring division on magnitudes, one quotient bit per cycle, sign-corrected at completion.
  - Quotient takes the sign of A xor B; remainder takes the sign of A.
  - Divide by zero: DIV/DIVU return all-ones; REM/REMU return A.
  - Signed overflow (A = most-negative, B = −1): DIV returns A; REM returns 0.
- After the counter reaches 0, the result is latched and the FSM goes to DONE.
- DONE: out_valid = 1. Result and flags stay stable until out_ready = 1, then the FSM returns to IDLE.
- Arithmetic and flags:
  - SUB computes A + ~B + 1 on XLEN+1 bits.
  - carry = bit XLEN of the sum, ADD/SUB only; 0 for all other ops.
  - overflow = operands (after B inversion) share a sign and the sum sign differs, ADD/SUB only; 0 for all other ops.
  - SLT = sum[XLEN-1] ^ overflow, which is correct across sign overflow. SLTU = ~carry of the subtraction. Both are zero-extended.
  - SRA replicates A[XLEN-1]. Shifts use B[SHW-1:0] only.
  - zero = (Result == 0) and neg = Result[XLEN-1], for every op.
- in_valid while not in IDLE is ignored; operands need not be held after acceptance.

## Timing
- Reset (rst high at a clock edge) forces IDLE from any state, including mid-iteration; the in-flight operation is discarded.
- Reset values: out_valid = 0, busy = 0, Result = 0, all flags = 0. in_ready = 1 from the first cycle after reset.
- Fast op accepted at edge N → out_valid high from edge N+1.
- Mul/div accepted at edge N → busy high during edges N+1..N+XLEN; out_valid high from edge N+XLEN+1.
- Handshake completes at the first edge with out_valid && out_ready. in_ready rises at the next cycle, so peak throughput is one fast op per 2 cycles.
- out_ready held high permanently gives DONE a duration of exactly one cycle.
- Backpressure: Result and flags are unchanged for every cycle of out_valid && !out_ready.
- No combinational path from in_valid, A, B or ALUControl to any output.

## Test plan
- Reset then ADD 0x7FFFFFFF + 0x00000001, out_ready = 1 → one cycle later: Result 0x80000000, overflow 1, neg 1, carry 0, zero 0.
- SUB 5 − 5 → Result 0, zero 1, carry 1. SLT 0x80000000 vs 0x00000001 → 1. SLTU with the same operands → 0. SRA 0x80000000 by 4 → 0xF8000000.
- MULH 0xFFFFFFFF × 0xFFFFFFFF → 0x00000000. MULHU with the same operands → 0xFFFFFFFE. MULHSU 0xFFFFFFFF × 0x00000002 → 0xFFFFFFFF. Each: out_valid exactly 33 cycles after accept, busy high for 32.
- DIV 0x80000000 / 0xFFFFFFFF → 0x80000000; REM of the same → 0. DIVU 7 / 0 → 0xFFFFFFFF; REMU 7 / 0 → 7. DIV −7 / 2 → −3; REM −7 / 2 → −1.
- Backpressure: hold out_ready = 0 for 10 cycles after out_valid → Result stable, in_ready 0, a new in_valid is ignored. Release → in_ready 1 next cycle.
- Assert rst at iteration 15 of a DIVU → next cycle: IDLE, out_valid 0, busy 0, Result 0. A following ADD completes normally.
